// File: rtl/stab_pass_ctrl.sv
// stab_pass_ctrl: owns a num_qubit-row stabilizer tableau and streams it through the gate datapath
// once per start pulse, writing processed rows back in order. Define STAB_PASS_CNT_EN for pass_count.
module stab_pass_ctrl #(
   parameter int num_qubit = 3
) (
   input  logic                   clk,
   input  logic                   rst_new,
   input  logic                   start,
   output logic                   busy,
   output logic                   init_done,
   output logic [2*num_qubit-1:0] row_literals_out,
   output logic                   row_phase_out,
   output logic                   row_valid_out,
   input  logic                   row_ready_in,
   input  logic [2*num_qubit-1:0] row_literals_in,
   input  logic                   row_phase_in,
   input  logic                   row_valid_in,
   output logic                   pass_done,
`ifdef STAB_PASS_CNT_EN
   output logic [15:0]            pass_count,
`endif
   output logic                   seq_err
);

   localparam int LW = 2 * num_qubit;
   localparam int IW = $clog2(num_qubit + 1);
   localparam logic [IW-1:0] NQ   = IW'(num_qubit);
   localparam logic [IW-1:0] LAST = IW'(num_qubit - 1);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_issue_idx;
   logic [IW-1:0]   r_ret_idx;
   logic [LW-1:0]   r_tab_lit [num_qubit];
   logic            r_tab_ph  [num_qubit];
   logic            r_busy;
   logic            r_init_done;
   logic [LW-1:0]   r_row_lit;
   logic            r_row_ph;
   logic            r_row_valid;
   logic            r_pass_done;
   logic            r_seq_err;

   logic            w_hs;
   logic            w_outstanding;
   logic            w_ret_ok;
   logic [IW-1:0]   w_next_idx;
   logic [LW-1:0]   w_init_row;

   // Issue side: a row transfers on any edge where row_valid_out && row_ready_in; once valid is
   // raised the row is held unchanged until that edge. Return side has no ready and is always taken.
   assign w_hs          = r_row_valid && row_ready_in;
   assign w_outstanding = (r_ret_idx < r_issue_idx) || (w_hs && (r_ret_idx == r_issue_idx));
   assign w_ret_ok      = row_valid_in && ((r_state == S_STREAM) || (r_state == S_WAIT)) && w_outstanding;
   assign w_next_idx    = r_issue_idx + IW'(1);
   assign w_init_row    = LW'(1) << {r_issue_idx, 1'b0};

   always_ff @(posedge clk) begin
      if (rst_new) begin
         r_state     <= S_INIT;
         r_issue_idx <= '0;
         r_ret_idx   <= '0;
         r_busy      <= 1'b1;
         r_init_done <= 1'b0;
         r_pass_done <= 1'b0;
         r_row_valid <= 1'b0;
         r_seq_err   <= 1'b0;
         r_row_lit   <= '0;
         r_row_ph    <= 1'b0;
      end else begin
         r_pass_done <= 1'b0;
         if (w_ret_ok) begin
            r_tab_lit[r_ret_idx] <= row_literals_in;
            r_tab_ph[r_ret_idx]  <= row_phase_in;
            r_ret_idx            <= r_ret_idx + IW'(1);
         end else if (row_valid_in) begin
            r_seq_err <= 1'b1;
         end
         case (r_state)
            S_INIT: begin
               r_tab_lit[r_issue_idx] <= w_init_row;
               r_tab_ph[r_issue_idx]  <= 1'b0;
               if (r_issue_idx == LAST) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_init_done <= 1'b1;
                  r_issue_idx <= '0;
               end else begin
                  r_issue_idx <= w_next_idx;
               end
            end
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_STREAM;
                  r_busy      <= 1'b1;
                  r_issue_idx <= '0;
                  r_ret_idx   <= '0;
                  r_row_valid <= 1'b1;
                  r_row_lit   <= r_tab_lit[0];
                  r_row_ph    <= r_tab_ph[0];
               end
            end
            S_STREAM: begin
               if (w_hs) begin
                  r_issue_idx <= w_next_idx;
                  if (r_issue_idx == LAST) begin
                     r_row_valid <= 1'b0;
                     r_state     <= S_WAIT;
                  end else begin
                     r_row_lit <= r_tab_lit[w_next_idx];
                     r_row_ph  <= r_tab_ph[w_next_idx];
                  end
               end
            end
            S_WAIT: begin
               if (r_ret_idx == NQ) begin
                  r_state     <= S_DONE;
                  r_pass_done <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_row_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef STAB_PASS_CNT_EN
   logic [15:0] r_pass_count;

   always_ff @(posedge clk) begin
      if (rst_new) begin
         r_pass_count <= '0;
      end else if (r_state == S_DONE) begin
         r_pass_count <= r_pass_count + 16'd1;
      end
   end

   assign pass_count = r_pass_count;
`endif

   assign busy             = r_busy;
   assign init_done        = r_init_done;
   assign row_literals_out = r_row_lit;
   assign row_phase_out    = r_row_ph;
   assign row_valid_out    = r_row_valid;
   assign pass_done        = r_pass_done;
   assign seq_err          = r_seq_err;

endmodule

// File: tb/tb_stab_pass_ctrl.sv
// tb_stab_pass_ctrl: scoreboard bench for stab_pass_ctrl; a reference tableau predicts every issued
// row, and a small datapath model echoes or transforms rows with programmable latency.
module tb_stab_pass_ctrl;

   localparam int N  = 3;
   localparam int LW = 2 * N;
   localparam int W  = LW + 1;

   typedef struct {
      int           due;
      logic [W-1:0] data;
   } ret_t;

   logic          clk = 1'b0;
   logic          rst_new;
   logic          start;
   logic          busy;
   logic          init_done;
   logic [LW-1:0] row_literals_out;
   logic          row_phase_out;
   logic          row_valid_out;
   logic          row_ready_in;
   logic [LW-1:0] row_literals_in;
   logic          row_phase_in;
   logic          row_valid_in;
   logic          pass_done;
   logic          seq_err;
`ifdef STAB_PASS_CNT_EN
   logic [15:0]   pass_count;
`endif

   int            n_vec;
   int            n_err;
   bit            exp_err;
   logic [LW-1:0] m_lit [N];
   logic          m_ph  [N];
   logic [W-1:0]  exp_q [$];

   stab_pass_ctrl #(.num_qubit(N)) dut (
      .clk              (clk),
      .rst_new          (rst_new),
      .start            (start),
      .busy             (busy),
      .init_done        (init_done),
      .row_literals_out (row_literals_out),
      .row_phase_out    (row_phase_out),
      .row_valid_out    (row_valid_out),
      .row_ready_in     (row_ready_in),
      .row_literals_in  (row_literals_in),
      .row_phase_in     (row_phase_in),
      .row_valid_in     (row_valid_in),
      .pass_done        (pass_done),
`ifdef STAB_PASS_CNT_EN
      .pass_count       (pass_count),
`endif
      .seq_err          (seq_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Gate model: invert phase and turn every Z literal into X.
   function automatic logic [W-1:0] xform(input logic [W-1:0] r);
      logic [W-1:0] o;
      o = r;
      o[W-1] = ~r[W-1];
      for (int q = 0; q < N; q++)
         if (r[2*q +: 2] == 2'd1) o[2*q +: 2] = 2'd2;
      return o;
   endfunction

   task automatic model_init();
      for (int k = 0; k < N; k++) begin
         m_lit[k] = '0;
         m_lit[k][2*k +: 2] = 2'd1;
         m_ph[k] = 1'b0;
      end
   endtask

   task automatic do_reset(input bit poke_start, input string name);
      int k;
      rst_new = 1'b1; start = 1'b0; row_ready_in = 1'b0; row_valid_in = 1'b0;
      tick();
      rst_new = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || init_done !== 1'b0 || pass_done !== 1'b0 || row_valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL %s ctrl_after_reset: got busy=%b init_done=%b pass_done=%b valid=%b, want 1 0 0 0",
                  name, busy, init_done, pass_done, row_valid_out);
      end
      n_vec++;
      if ({row_phase_out, row_literals_out} !== '0) begin
         n_err++;
         $display("FAIL %s row_out_after_reset: got %0h want 0", name, {row_phase_out, row_literals_out});
      end
      n_vec++;
      if (seq_err !== 1'b0) begin
         n_err++;
         $display("FAIL %s seq_err_after_reset: got %b want 0", name, seq_err);
      end
      start = poke_start;
      k = 0;
      while (init_done !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      start = 1'b0;
      n_vec++;
      if (k !== N) begin
         n_err++;
         $display("FAIL %s init_latency: got %0d cycles want %0d", name, k, N);
      end
      model_init();
      exp_err = 1'b0;
      repeat (2) tick();
      n_vec++;
      if (busy !== 1'b0 || row_valid_out !== 1'b0 || init_done !== 1'b1) begin
         n_err++;
         $display("FAIL %s idle_after_init: got busy=%b valid=%b init_done=%b want 0 0 1",
                  name, busy, row_valid_out, init_done);
      end
   endtask

   // rmode: 0 = ready toggles starting low, 1 = ready held high, 2 = random ready.
   task automatic run_pass(input int lat, input bit xf, input int rmode, input bit poke,
                           input int exp_done, input string name);
      ret_t         pend [$];
      ret_t         ent;
      logic [W-1:0] got;
      logic [W-1:0] want;
      int           cyc, hs_n, ret_n, done_n, done_cyc;
      cyc = 0; hs_n = 0; ret_n = 0; done_n = 0; done_cyc = 0;
      exp_q.delete();
      for (int k = 0; k < N; k++) exp_q.push_back({m_ph[k], m_lit[k]});
      start = 1'b1;
      while (cyc < 100 && !(done_n > 0 && cyc >= done_cyc + 2)) begin
         tick();
         cyc++;
         start = poke && (cyc == 2);
         case (rmode)
            0:       row_ready_in = (cyc % 2 == 0);
            1:       row_ready_in = 1'b1;
            default: row_ready_in = 1'($urandom_range(0, 1));
         endcase
         if (row_valid_out === 1'b1) begin
            got = {row_phase_out, row_literals_out};
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL %s extra_row: got %0h, no row expected", name, got);
            end else begin
               if (got !== exp_q[0]) begin
                  n_err++;
                  $display("FAIL %s row_data cyc %0d: got %0h want %0h", name, cyc, got, exp_q[0]);
               end
               if (row_ready_in) begin
                  want = exp_q.pop_front();
                  hs_n++;
                  ent.due  = cyc + lat;
                  ent.data = xf ? xform(want) : want;
                  pend.push_back(ent);
               end
            end
         end
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            ent = pend.pop_front();
            row_valid_in = 1'b1;
            {row_phase_in, row_literals_in} = ent.data;
            if (ret_n < N) begin
               m_lit[ret_n] = ent.data[LW-1:0];
               m_ph[ret_n]  = ent.data[W-1];
            end
            ret_n++;
         end else begin
            row_valid_in = 1'b0;
         end
         if (pass_done === 1'b1) begin
            done_n++;
            if (done_n == 1) done_cyc = cyc;
         end
      end
      start = 1'b0; row_ready_in = 1'b0; row_valid_in = 1'b0;
      n_vec++;
      if (done_n !== 1) begin
         n_err++;
         $display("FAIL %s pass_done_count: got %0d pulses in %0d cycles want 1", name, done_n, cyc);
      end
      n_vec++;
      if (hs_n !== N || exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL %s handshakes: got %0d want %0d (left %0d)", name, hs_n, N, exp_q.size());
      end
      if (exp_done > 0) begin
         n_vec++;
         if (done_cyc !== exp_done) begin
            n_err++;
            $display("FAIL %s pass_latency: got %0d want %0d", name, done_cyc, exp_done);
         end
      end
      n_vec++;
      if (busy !== 1'b0 || row_valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle_after_pass: got busy=%b valid=%b want 0 0", name, busy, row_valid_out);
      end
      n_vec++;
      if (seq_err !== exp_err) begin
         n_err++;
         $display("FAIL %s seq_err_after_pass: got %b want %b", name, seq_err, exp_err);
      end
   endtask

   task automatic test_reset();
      do_reset(1'b0, "reset");
   endtask

   task automatic test_echo();
      run_pass(0, 1'b0, 1, 1'b0, N + 2, "echo");
      run_pass(0, 1'b0, 1, 1'b0, N + 2, "echo_again");
   endtask

   task automatic test_latency_xform();
      run_pass(3, 1'b1, 1, 1'b0, 0, "lat3_xform");
      run_pass(0, 1'b0, 1, 1'b0, N + 2, "after_xform");
   endtask

   task automatic test_ready_toggle();
      run_pass(0, 1'b0, 0, 1'b0, 2 * N + 2, "ready_toggle");
   endtask

   task automatic test_start_ignored();
      do_reset(1'b1, "start_in_init");
      run_pass(0, 1'b0, 1, 1'b1, N + 2, "start_mid_stream");
   endtask

   task automatic test_random_ready();
      run_pass(1, 1'b1, 2, 1'b0, 0, "random_ready_xform");
      run_pass(2, 1'b0, 2, 1'b0, 0, "random_ready_echo");
   endtask

   task automatic test_seq_err_idle();
      row_valid_in = 1'b1;
      row_literals_in = LW'($urandom);
      row_phase_in = 1'b1;
      tick();
      row_valid_in = 1'b0;
      n_vec++;
      if (seq_err !== 1'b1) begin
         n_err++;
         $display("FAIL seq_err_idle set: got %b want 1", seq_err);
      end
      repeat (3) tick();
      n_vec++;
      if (seq_err !== 1'b1) begin
         n_err++;
         $display("FAIL seq_err_idle sticky: got %b want 1", seq_err);
      end
      exp_err = 1'b1;
      run_pass(0, 1'b0, 1, 1'b0, N + 2, "pass_after_err");
   endtask

   task automatic test_reset_mid_stream();
      start = 1'b1;
      tick();
      start = 1'b0;
      row_ready_in = 1'b1;
      tick();
      tick();
      n_vec++;
      if (row_valid_out !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL mid_stream_setup: got valid=%b busy=%b want 1 1", row_valid_out, busy);
      end
      do_reset(1'b0, "reset_mid_stream");
      run_pass(0, 1'b0, 1, 1'b0, N + 2, "pass_after_reinit");
   endtask

   initial begin
      n_vec = 0; n_err = 0; exp_err = 1'b0;
      rst_new = 1'b1; start = 1'b0; row_ready_in = 1'b0;
      row_valid_in = 1'b0; row_literals_in = '0; row_phase_in = 1'b0;
      model_init();
      test_reset();
      test_echo();
      test_latency_xform();
      test_ready_toggle();
      test_start_ignored();
      test_random_ready();
      test_seq_err_idle();
      test_reset_mid_stream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stab_pass_ctrl.md
Name: stab_pass_ctrl

Overview:
- Owns the stabilizer tableau of num_qubit rows and sequences whole-tableau passes through the downstream gate datapath.
- After reset it loads the |0..0> basis state itself (row k = Z on qubit k, phase 0).
- On each start pulse it streams every row out with valid/ready, collects the processed rows in order, and writes them back into its own storage.
- Sits between the emulation top-level sequencer and the gate-application unit.

Parameters:
num_qubit, 3, qubits per row and number of rows in the tableau (>=1)

Ports:
clk  in  1  clock
rst_new  in  1  synchronous reset, active-high
start  in  1  single-cycle request to run one pass; honoured only in IDLE
busy  out  1  high in INIT, STREAM, WAIT, DONE
init_done  out  1  level; high once the initial tableau has been written, until next reset
row_literals_out  out  2 x [0:num_qubit-1]  row issued to datapath; literal code 0=I, 1=Z, 2=X, 3=Y
row_phase_out  out  1  phase of issued row (0 = +, 1 = -)
row_valid_out  out  1  issued row valid
row_ready_in  in  1  datapath accepts issued row
row_literals_in  in  2 x [0:num_qubit-1]  processed row returned from datapath
row_phase_in  in  1  phase of returned row
row_valid_in  in  1  returned row valid; no ready, so it must always be accepted
pass_done  out  1  one-cycle pulse when all rows are written back
seq_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Storage: num_qubit x (2*num_qubit+1) register array.
- Indices issue_idx and ret_idx are $clog2(num_qubit+1) bits wide.
- Reset (rst_new high at a clock edge; synchronous, active-high, takes priority over everything, including mid-pass):
  - state <= INIT; issue_idx and ret_idx <= 0.
  - busy=1, init_done=0, pass_done=0, row_valid_out=0, seq_err=0.
  - row_literals_out all 0, row_phase_out=0.
- INIT:
  - Writes one row per cycle: row issue_idx <= all I except Z at column issue_idx, phase 0.
  - After row num_qubit-1 is written: state IDLE, init_done <= 1, issue_idx <= 0. Takes num_qubit cycles.
  - start is ignored during INIT.
- IDLE: busy=0, row_valid_out=0. On start=1: state STREAM, issue_idx <= 0, ret_idx <= 0.
- STREAM:
  - Outputs are registered: row_valid_out=1 with the contents of row issue_idx.
  - Data stays stable while row_ready_in=0.
  - On valid&&ready: issue_idx++ and the next row is presented the following cycle, so one row per cycle when ready is held high.
  - After the handshake on row num_qubit-1: row_valid_out <= 0, state WAIT.
- Return path, active in STREAM and WAIT:
  - If row_valid_in=1 and ret_idx < issue_idx: write row ret_idx <= (row_literals_in, row_phase_in), then ret_idx++.
  - A return in the same cycle as the handshake of row ret_idx counts as outstanding and is accepted (zero-latency datapath).
  - If row_valid_in=1 with no outstanding row, in any other state, or when ret_idx = num_qubit: write is dropped and seq_err <= 1.
- WAIT: once ret_idx == num_qubit, state DONE.
- DONE: pass_done=1 for exactly one cycle, then state IDLE.
  - Minimum pass length with ready always high and zero latency: num_qubit + 2 cycles from the start sample to the pass_done cycle.
- start outside IDLE is ignored; it is not queued.
- Rows are written back in issue order. A row being written is never the row being presented, because ret_idx < issue_idx.

Optional Feature:
- Macro: STAB_PASS_CNT_EN.
- Defined:
  - Adds output pass_count, 16 bits.
  - Reset to 0; increments in the DONE cycle; wraps 16'hFFFF -> 0.
- Undefined: no pass_count port; no counter logic.

Test Plan:
- Reset with num_qubit=3 -> init_done rises after 3 cycles. Tableau rows are (Z,I,I),(I,Z,I),(I,I,Z), phase 0. seq_err=0.
- start, ready=1, datapath echoes each row the same cycle -> rows 0,1,2 appear on consecutive cycles. pass_done pulses once. Tableau unchanged.
- Datapath returns each row 3 cycles late with phase inverted and Z->X -> second pass issues (X,I,I) phase 1, etc.
- row_ready_in toggled 0/1 every cycle -> each row held stable until accepted. No row skipped or duplicated. pass_done after 6 handshake-window cycles.
- start pulsed in INIT and mid-STREAM -> ignored; exactly one pass_done per accepted start.
- row_valid_in asserted in IDLE -> seq_err=1 and stays high; tableau unchanged. rst_new mid-STREAM -> INIT restarts, tableau re-initialised, seq_err cleared.
